print_uart_tx: RTL and testbench

Serializing consumer for the core's print port. It captures every 32-bit word the core emits on PRINT_VAL/PRINT_EN (a store to the print address) into a small FIFO. Each word is transmitted as 8 lowercase hex ASCII digits, most significant nibble first, followed by LF, on a UART 8N1 line. It sits beside the core at the top level, so simulation and FPGA builds get the same console text without stalling the core.

---
 rtl/print_uart_pkg.sv | 16 +
 rtl/print_uart_tx_fifo.sv | 45 ++++
 rtl/print_uart_tx.sv | 150 +++++++++++++++
 tb/tb_print_uart_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/print_uart_pkg.sv
// Shared types, ASCII constants and the nibble-to-hex-character helper
// for the print-port UART serializer.
package print_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h61;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) return ASCII_0 + {4'h0, nibble};
    else                return ASCII_A + {4'h0, nibble} - 8'd10;
  endfunction

endpackage

// File: rtl/print_uart_tx_fifo.sv
// Single-clock word FIFO buffering print-port writes ahead of the UART.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module print_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/print_uart_tx.sv
// Prints each captured 32-bit word as 8 lowercase hex digits plus LF on
// an 8N1 UART line, back-to-back while words remain queued.
module print_uart_tx
  import print_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PRINT_VAL,
  input  logic        PRINT_EN,
  output logic        TX,
  output logic        BUSY,
  output logic        OVERFLOW
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [3:0]        char_q, char_d;
  logic [31:0]       word_q, word_d;
  logic              tx_q, tx_d;
  logic              ovf_q;

  logic [31:0] fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;

  logic        baud_end;
  logic [31:0] word_shl;
  logic [7:0]  char_byte;
  logic [2:0]  bit_nxt;

  print_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (PRINT_EN),
    .din   (PRINT_VAL),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Current character: the selected nibble is shifted up to the top of the word.
  assign word_shl  = word_q << {char_q[2:0], 2'b00};
  assign char_byte = (char_q == 4'd8) ? ASCII_LF : hex_ascii(word_shl[31:28]);
  assign bit_nxt   = bit_q + 3'd1;
  assign baud_end  = (baud_q == BAUD_LAST);

  // TX is registered and loaded on the same edge as the state change,
  // so each level lasts exactly one bit time from its transition edge.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_end ? '0 : baud_q + 1'b1;
    bit_d    = bit_q;
    char_d   = char_q;
    word_d   = word_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          word_d   = fifo_dout;
          char_d   = 4'd0;
          state_d  = START;
          tx_d     = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = char_byte[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nxt;
            tx_d  = char_byte[bit_nxt];
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          if (char_q < 4'd8) begin
            char_d  = char_q + 4'd1;
            state_d = START;
            tx_d    = 1'b0;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            word_d   = fifo_dout;
            char_d   = 4'd0;
            state_d  = START;
            tx_d     = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      char_q  <= 4'd0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_q | (PRINT_EN & fifo_full);
    end
  end

  always_ff @(posedge CLK) begin
    word_q <= word_d;
  end

  assign TX       = tx_q;
  assign BUSY     = (state_q != IDLE) | ~fifo_empty;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_print_uart_tx.sv
// Directed/random bench for print_uart_tx: expected TX waveforms are built
// from the printed text ("%08h\n") and the 8N1 frame rules.
module tb_print_uart_tx;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] PRINT_VAL;
  logic        en0, en1, en2;
  logic        tx0, tx1, tx2;
  logic        busy0, busy1, busy2;
  logic        ovf0, ovf1, ovf2;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] push_q[$];
  logic [31:0] exp_q[$];

  always #5 CLK = ~CLK;

  print_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_dut4 (
    .CLK(CLK), .RESET(RESET), .PRINT_VAL(PRINT_VAL), .PRINT_EN(en0),
    .TX(tx0), .BUSY(busy0), .OVERFLOW(ovf0));

  print_uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .PRINT_VAL(PRINT_VAL), .PRINT_EN(en1),
    .TX(tx1), .BUSY(busy1), .OVERFLOW(ovf1));

  print_uart_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) u_dut16 (
    .CLK(CLK), .RESET(RESET), .PRINT_VAL(PRINT_VAL), .PRINT_EN(en2),
    .TX(tx2), .BUSY(busy2), .OVERFLOW(ovf2));

  function automatic logic tx_of(input int s);
    case (s)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic busy_of(input int s);
    case (s)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic ovf_of(input int s);
    case (s)
      0:       return ovf0;
      1:       return ovf1;
      default: return ovf2;
    endcase
  endfunction

  function automatic int cpb(input int s);
    case (s)
      0:       return 4;
      1:       return 2;
      default: return 16;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_en(input int s, input logic v);
    en0 = (s == 0) ? v : 1'b0;
    en1 = (s == 1) ? v : 1'b0;
    en2 = (s == 2) ? v : 1'b0;
  endtask

  // Pushes push_q on consecutive edges and checks the TX line cycle by cycle
  // against the ideal 8N1 waveform of the text made from exp_q.
  task automatic run_stream(input int sel, input logic exp_ovf);
    int         c;
    int         total;
    int         i;
    int         ch;
    int         pos;
    int         mism;
    int         busy_lo;
    string      s;
    logic [7:0] b;
    logic [7:0] dec;
    logic       expbit;
    c       = cpb(sel);
    s       = "";
    mism    = 0;
    busy_lo = 0;
    dec     = 8'h00;
    foreach (exp_q[k]) s = {s, $sformatf("%08h\n", exp_q[k])};
    total = s.len() * 10 * c;
    PRINT_VAL = push_q[0];
    set_en(sel, 1'b1);
    for (int t = 0; t <= total; t++) begin
      @(negedge CLK);
      if (t + 1 < push_q.size()) PRINT_VAL = push_q[t + 1];
      else set_en(sel, 1'b0);
      if (t == 0) begin
        chk($sformatf("s%0d_tx_before_start", sel), 32'(tx_of(sel)), 32'd1);
        chk($sformatf("s%0d_busy_after_push", sel), 32'(busy_of(sel)), 32'd1);
      end else begin
        i   = t - 1;
        ch  = i / (10 * c);
        pos = (i % (10 * c)) / c;
        b   = s[ch];
        if (pos == 0)      expbit = 1'b0;
        else if (pos == 9) expbit = 1'b1;
        else               expbit = b[pos - 1];
        if (tx_of(sel) !== expbit) mism++;
        if (busy_of(sel) !== 1'b1) busy_lo++;
        if (pos >= 1 && pos <= 8 && (i % c) == c / 2) dec[pos - 1] = tx_of(sel);
        if ((i % (10 * c)) == 10 * c - 1) begin
          chk($sformatf("s%0d_char%0d_byte", sel, ch), {24'h0, dec}, {24'h0, b});
          chk($sformatf("s%0d_char%0d_wave_errs", sel, ch), 32'(mism), 32'd0);
          mism = 0;
        end
      end
    end
    @(negedge CLK);
    chk($sformatf("s%0d_busy_low_cycles", sel), 32'(busy_lo), 32'd0);
    chk($sformatf("s%0d_busy_released", sel), 32'(busy_of(sel)), 32'd0);
    chk($sformatf("s%0d_tx_idle_after", sel), 32'(tx_of(sel)), 32'd1);
    chk($sformatf("s%0d_overflow", sel), 32'(ovf_of(sel)), 32'(exp_ovf));
    push_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] w;
    string       rs;
    logic [7:0]  rb;
    RESET     = 1'b1;
    PRINT_VAL = 32'h0;
    set_en(0, 1'b0);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("reset_tx0", 32'(tx0), 32'd1);
    chk("reset_busy0", 32'(busy0), 32'd0);
    chk("reset_ovf0", 32'(ovf0), 32'd0);
    chk("reset_tx_all", {29'h0, tx2, tx1, tx0}, 32'h7);
    chk("reset_busy_all", {29'h0, busy2, busy1, busy0}, 32'h0);

    // Single word at 4 clocks per bit.
    push_q = '{32'h0000_00ff};
    exp_q  = '{32'h0000_00ff};
    run_stream(0, 1'b0);

    // Two words on consecutive cycles, printed with no gap.
    push_q = '{32'hdead_beef, 32'h1234_5678};
    exp_q  = '{32'hdead_beef, 32'h1234_5678};
    run_stream(0, 1'b0);

    // Three random words back-to-back, within FIFO capacity.
    for (int k = 0; k < 3; k++) begin
      w = $urandom;
      push_q.push_back(w);
      exp_q.push_back(w);
    end
    run_stream(0, 1'b0);

    // Bit-time checks at the smallest and default baud dividers.
    w = $urandom;
    push_q = '{w};
    exp_q  = '{w};
    run_stream(1, 1'b0);
    w = $urandom;
    push_q = '{w};
    exp_q  = '{w};
    run_stream(2, 1'b0);

    // Six pushes into depth 4: one pop frees a slot, the sixth is dropped.
    for (int k = 0; k < 6; k++) begin
      w = $urandom;
      push_q.push_back(w);
      if (k < 5) exp_q.push_back(w);
    end
    run_stream(0, 1'b1);
    repeat (5) @(negedge CLK);
    chk("ovf_sticky", 32'(ovf0), 32'd1);

    // Reset during the third character's data bits.
    w = $urandom;
    PRINT_VAL = w;
    set_en(0, 1'b1);
    @(negedge CLK);
    set_en(0, 1'b0);
    repeat (1 + 23 * 4) @(negedge CLK);
    rs = $sformatf("%08h", w);
    rb = rs[2];
    chk("midframe_tx_bit", 32'(tx0), 32'(rb[2]));
    chk("midframe_busy", 32'(busy0), 32'd1);
    chk("midframe_ovf_still_set", 32'(ovf0), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("after_reset_tx", 32'(tx0), 32'd1);
    chk("after_reset_busy", 32'(busy0), 32'd0);
    chk("after_reset_ovf", 32'(ovf0), 32'd0);
    @(negedge CLK);
    push_q = '{32'h0};
    exp_q  = '{32'h0};
    run_stream(0, 1'b0);

    // PRINT_VAL toggling without PRINT_EN must leave everything idle.
    set_en(0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      PRINT_VAL = $urandom;
      @(negedge CLK);
      if ((k % 5) == 4) begin
        chk("noen_tx", {29'h0, tx2, tx1, tx0}, 32'h7);
        chk("noen_busy", {29'h0, busy2, busy1, busy0}, 32'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
